div_iter: RTL and testbench

//  Iterative radix-2 restoring divider: the inverse operator to the pipelined multiplier.
//  - Same req/flush/ready handshake as the multiplier, so the execute stage drives both identically.
//  - One operation in flight, one quotient bit per clock.
//  - Returns quotient and remainder of a_i / b_i.

---
 rtl/div_iter_pkg.sv | 19 +
 rtl/div_iter_step.sv | 26 ++
 rtl/div_iter.sv | 147 ++++++++++++++
 tb/tb_div_iter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Purpose: state encodings shared by the iterative divider and the pipelined multiplier FSMs.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package div_iter_pkg;

  // 2'b11 is never entered deliberately; both FSMs treat it as a fault and recover to IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10,
    UNUSED = 2'b11
  } state_t;

  // Iteration counter width: enough to hold XLEN with one bit of headroom
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// Purpose: one radix-2 restoring division step (shift in dividend bit, compare, subtract).
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider is calculating.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  // Partial remainder is XLEN+1 bits so the shifted value never loses its carry
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {rem_i, dvd_msb_i};
  assign w_diff  = w_shift - {1'b0, dvs_i};

  // rem_i < dvs_i always holds, so w_shift - dvs_i lies in [-dvs_i, dvs_i-1] and the
  // top bit of the XLEN+1 bit difference is a clean borrow: clear means shift >= divisor
  assign q_bit_o = ~w_diff[XLEN];
  assign rem_o   = q_bit_o ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/div_iter.sv
// Purpose: iterative radix-2 restoring divider, quotient and remainder of a_i / b_i; signed mode via DIV_SIGNED_EN.
// Latency: ready_o pulses XLEN edges after acceptance (one edge for divide-by-zero); one op per XLEN+2 cycles.
// Backpressure: none; req_i is only sampled in IDLE and is dropped (not queued) while busy; flush_i aborts CALC.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = cnt_width(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvd;   // dividend shifts out at the top, quotient bits shift in at the bottom
  logic [XLEN-1:0] r_dvs;
  logic            r_ready;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rmd;

  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_rem_next;
  logic            w_q_bit;
  logic [XLEN-1:0] w_q_raw;
  logic [XLEN-1:0] w_r_raw;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic            w_accept;

  assign w_accept = (r_state == IDLE) && req_i && !flush_i;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (r_rem),
    .dvd_msb_i (r_dvd[XLEN-1]),
    .dvs_i     (r_dvs),
    .rem_o     (w_rem_next),
    .q_bit_o   (w_q_bit)
  );

  // Result of the final step, before any sign correction
  assign w_q_raw = {r_dvd[XLEN-2:0], w_q_bit};
  assign w_r_raw = w_rem_next;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Magnitudes feed the unsigned core; |MIN| is representable as an unsigned XLEN value
  assign w_a_mag = a_i[XLEN-1] ? -a_i : a_i;
  assign w_b_mag = b_i[XLEN-1] ? -b_i : b_i;

  // Quotient truncates toward zero, remainder follows the dividend's sign
  assign w_q_fix = r_neg_q ? -w_q_raw : w_q_raw;
  assign w_r_fix = r_neg_r ? -w_r_raw : w_r_raw;

  // Capture the result signs alongside the operands on the accepting edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= a_i[XLEN-1] ^ b_i[XLEN-1];
      r_neg_r <= a_i[XLEN-1];
    end
  end
`else
  assign w_a_mag = a_i;
  assign w_b_mag = b_i;
  assign w_q_fix = w_q_raw;
  assign w_r_fix = w_r_raw;
`endif

  // Control FSM, iteration datapath and registered results
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_ready <= 1'b0;
      r_quot  <= '0;
      r_rmd   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= w_a_mag;
            r_dvs <= w_b_mag;
            if (b_i == '0) begin
              // Divide-by-zero skips the iterations; the bit pattern is the same signed or unsigned
              r_quot  <= '1;
              r_rmd   <= a_i;
              r_ready <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_q_raw;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_STEP) begin
              r_quot  <= w_q_fix;
              r_rmd   <= w_r_fix;
              r_ready <= 1'b1;
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign quotient_o  = r_quot;
  assign remainder_o = r_rmd;

endmodule

// File: tb/tb_div_iter.sv
// Purpose: self-checking bench for div_iter (directed corner cases plus randomized traffic).
// Latency: n/a.
// Backpressure: n/a.
module tb_div_iter;
  localparam int XLEN = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        flush_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  int checks = 0;
  int errors = 0;

  div_iter #(.XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .flush_i     (flush_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .ready_o     (ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain division on wide integers
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Timeline model: an accepted op produces its result XLEN edges later (same edge if b==0),
  // the unit is free again two edges after the result edge's predecessor, flush kills a pending op
  logic        exp_ready = 1'b0;
  logic [31:0] exp_q = 32'd0;
  logic [31:0] exp_r = 32'd0;
  bit          m_act = 1'b0;
  int          m_pulse = 0;
  int          n = 0;
  logic [31:0] m_q;
  logic [31:0] m_r;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_act     = 1'b0;
      exp_ready = 1'b0;
      exp_q     = 32'd0;
      exp_r     = 32'd0;
    end else begin
      n++;
      exp_ready = 1'b0;
      if (m_act) begin
        if (flush_i && n <= m_pulse) m_act = 1'b0;
        else if (n == m_pulse) begin
          exp_ready = 1'b1;
          exp_q     = m_q;
          exp_r     = m_r;
        end else if (n == m_pulse + 1) m_act = 1'b0;
      end else if (req_i && !flush_i) begin
        ref_div(a_i, b_i, m_q, m_r);
        m_act = 1'b1;
        if (b_i == 32'd0) begin
          m_pulse   = n;
          exp_ready = 1'b1;
          exp_q     = m_q;
          exp_r     = m_r;
        end else begin
          m_pulse = n + XLEN;
        end
      end
    end
  end

  // Every cycle, all outputs must match the model
  always @(negedge clk_i) begin
    chk("model ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
    chk("model quotient_o", quotient_o, exp_q);
    chk("model remainder_o", remainder_o, exp_r);
  end

  // Issue a single-cycle request, scramble operands afterwards, count negedges until ready_o
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int k);
    req_i = 1'b1;
    a_i   = a;
    b_i   = b;
    @(negedge clk_i);
    req_i = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
    k     = 1;
    while (!ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk_i);
      if (ready_o) pulses++;
    end
  endtask

  initial begin
    int k;
    int pulses;
    int sel;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    flush_i = 1'b0;
    a_i     = 32'd0;
    b_i     = 32'd0;
    repeat (2) @(negedge clk_i);
    chk("reset ready_o", {31'd0, ready_o}, 32'd0);
    chk("reset quotient_o", quotient_o, 32'd0);
    chk("reset remainder_o", remainder_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 100 / 7
    run_op(32'd100, 32'd7, k);
    chk("100/7 latency", 32'(k), 32'd33);
    chk("100/7 quotient", quotient_o, 32'd14);
    chk("100/7 remainder", remainder_o, 32'd2);
    @(negedge clk_i);
    chk("100/7 pulse width", {31'd0, ready_o}, 32'd0);

    // 5 / 0
    run_op(32'd5, 32'd0, k);
    chk("5/0 latency", 32'(k), 32'd1);
    chk("5/0 quotient", quotient_o, 32'hFFFF_FFFF);
    chk("5/0 remainder", remainder_o, 32'd5);
    @(negedge clk_i);
    chk("5/0 pulse width", {31'd0, ready_o}, 32'd0);

    // 1000 / 3 flushed in CALC cycle 10
    req_i = 1'b1;
    a_i   = 32'd1000;
    b_i   = 32'd3;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    count_pulses(40, pulses);
    chk("flush no pulse", 32'(pulses), 32'd0);
    chk("flush keeps quotient", quotient_o, 32'hFFFF_FFFF);
    chk("flush keeps remainder", remainder_o, 32'd5);
    run_op(32'd9, 32'd3, k);
    chk("9/3 latency", 32'(k), 32'd33);
    chk("9/3 quotient", quotient_o, 32'd3);
    chk("9/3 remainder", remainder_o, 32'd0);
    @(negedge clk_i);

    // req_i held high: second op (10/3) only accepted after returning to IDLE
    req_i = 1'b1;
    a_i   = 32'hFFFF_FFFF;
    b_i   = 32'd1;
    @(negedge clk_i);
    a_i = 32'd10;
    b_i = 32'd3;
    k   = 1;
    while (!ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("held 1st latency", 32'(k), 32'd33);
    chk("held 1st quotient", quotient_o, 32'hFFFF_FFFF);
    chk("held 1st remainder", remainder_o, 32'd0);
    @(negedge clk_i);
    k++;
    while (!ready_o && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    req_i = 1'b0;
    chk("held 2nd latency", 32'(k), 32'd67);
    chk("held 2nd quotient", quotient_o, 32'd3);
    chk("held 2nd remainder", remainder_o, 32'd1);
    @(negedge clk_i);

    // 0xFFFFFFF9 / 2
    run_op(32'hFFFF_FFF9, 32'd2, k);
    chk("fff9/2 latency", 32'(k), 32'd33);
`ifdef DIV_SIGNED_EN
    chk("fff9/2 quotient", quotient_o, 32'hFFFF_FFFD);
    chk("fff9/2 remainder", remainder_o, 32'hFFFF_FFFF);
    @(negedge clk_i);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, k);
    chk("min/-1 quotient", quotient_o, 32'h8000_0000);
    chk("min/-1 remainder", remainder_o, 32'd0);
`else
    chk("fff9/2 quotient", quotient_o, 32'h7FFF_FFFC);
    chk("fff9/2 remainder", remainder_o, 32'd1);
`endif
    @(negedge clk_i);

    // Reset in the middle of CALC
    req_i = 1'b1;
    a_i   = 32'd50;
    b_i   = 32'd7;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("mid reset ready_o", {31'd0, ready_o}, 32'd0);
    chk("mid reset quotient_o", quotient_o, 32'd0);
    chk("mid reset remainder_o", remainder_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    count_pulses(40, pulses);
    chk("mid reset no pulse", 32'(pulses), 32'd0);

    // Randomized traffic checked every cycle against the model
    repeat (3000) begin
      @(negedge clk_i);
      req_i   = ($urandom_range(0, 2) == 0);
      flush_i = ($urandom_range(0, 30) == 0);
      sel     = int'($urandom_range(0, 15));
      a_i     = (sel < 4) ? 32'($urandom_range(0, 1000)) :
                (sel == 4) ? 32'h8000_0000 : $urandom;
      sel     = int'($urandom_range(0, 15));
      b_i     = (sel == 0) ? 32'd0 :
                (sel < 6)  ? 32'($urandom_range(1, 20)) :
                (sel < 8)  ? 32'hFFFF_FFFF : $urandom;
    end
    req_i   = 1'b0;
    flush_i = 1'b0;
    repeat (40) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
